// File: rtl/sram_access_controller.sv
// Responder for the SRAM request/result handshake: latches one request and sequences
// timed strobes on an asynchronous SRAM. Optional macro SRAM_FAST_TURNAROUND_EN.
//   state    | meaning
//   IDLE     | waiting for req_den; pins idle
//   SETUP    | ce_n low, address valid, write data driven or oe_n low
//   ACCESS   | WAIT_CYCLES cycles of we_n/oe_n low; read data sampled on the last one
//   HOLD     | strobes released, address/ce_n/write data kept stable
//   COMPLETE | res_done pulse, bus released
module sram_access_controller #(
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     req_address,
  input  logic [DATA_WIDTH-1:0]     req_dout,
  input  logic                      req_oe_n,
  input  logic                      req_we_n,
  input  logic                      req_den,
  output logic [DATA_WIDTH-1:0]     res_din,
  output logic                      res_done,
  output logic                      busy,
  output logic [ADDR_WIDTH-1:0]     sram_addr,
  inout  wire  [DATA_WIDTH-1:0]     sram_data,
  output logic                      sram_ce_n,
  output logic                      sram_oe_n,
  output logic                      sram_we_n,
  output logic [DATA_WIDTH/8-1:0]   sram_be_n
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_HOLD, S_COMPLETE} state_t;
  typedef enum logic [1:0] {OP_NOP, OP_READ, OP_WRITE} op_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  op_t                   r_op;
  op_t                   w_req_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_din;
  logic [3:0]            r_cnt;
  logic                  w_latch;
  logic                  w_drive;

  always_comb begin
    if (!req_we_n)      w_req_op = OP_WRITE;
    else if (!req_oe_n) w_req_op = OP_READ;
    else                w_req_op = OP_NOP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= OP_NOP;
      r_addr  <= '0;
      r_wdata <= '0;
      r_din   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_op    <= w_req_op;
        r_addr  <= req_address;
        r_wdata <= req_dout;
      end
      if (r_state == S_SETUP)
        r_cnt <= CNT_LOAD;
      else if (r_state == S_ACCESS && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      // Read data is taken at the edge that ends the final ACCESS cycle.
      if (r_state == S_ACCESS && r_cnt == 4'd0 && r_op == OP_READ)
        r_din <= sram_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_drive     = 1'b0;
    sram_ce_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_we_n   = 1'b1;
    busy        = (r_state != S_IDLE);
    res_done    = (r_state == S_COMPLETE);
    case (r_state)
      S_IDLE: begin
        if (req_den) begin
          w_latch     = 1'b1;
          w_state_nxt = (w_req_op == OP_NOP) ? S_COMPLETE : S_SETUP;
        end
      end
      S_SETUP: begin
        sram_ce_n   = 1'b0;
        sram_oe_n   = (r_op != OP_READ);
        w_drive     = (r_op == OP_WRITE);
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        sram_ce_n = 1'b0;
        sram_oe_n = (r_op != OP_READ);
        sram_we_n = (r_op != OP_WRITE);
        w_drive   = (r_op == OP_WRITE);
        if (r_cnt == 4'd0) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        sram_ce_n   = 1'b0;
        w_drive     = (r_op == OP_WRITE);
        w_state_nxt = S_COMPLETE;
      end
      S_COMPLETE: begin
        w_state_nxt = S_IDLE;
`ifdef SRAM_FAST_TURNAROUND_EN
        // Chip stays selected so a same-direction follow-on keeps ce_n low throughout.
        sram_ce_n = (r_op == OP_NOP);
        if (req_den && r_op != OP_NOP && w_req_op == r_op) begin
          w_latch     = 1'b1;
          w_state_nxt = S_SETUP;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign sram_addr = r_addr;
  assign res_din   = r_din;
  assign sram_be_n = {(DATA_WIDTH/8){sram_ce_n}};
  assign sram_data = w_drive ? r_wdata : {DATA_WIDTH{1'bz}};

endmodule
